// File: rtl/pwm.sv
// ----------------------------------------------------------------------------
// pwm -- fixed 50%-duty square-wave generator.
//
// The output period is programmed in microseconds and converted to clock
// cycles with the compile-time clock period CLK_PERIOD (ns). Each period is
// split into HIGH = floor(TOTAL/2) high cycles followed by TOTAL-HIGH low
// cycles, so an odd cycle count lengthens the low phase.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous, active-high reset (priority over enable)
//   enable      run control; low forces out=0 and rewinds to phase 0
//   pwm_period  period in microseconds (unsigned), sampled at phase 0 only
//   out         registered PWM output
// ----------------------------------------------------------------------------
module pwm #(
   parameter int CLK_PERIOD   = 10,
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [PERIOD_WIDTH-1:0] pwm_period,
   output logic                    out
);

   // Ten extra bits hold the product for any CYCLES_PER_US up to 1000.
   localparam int AW = PERIOD_WIDTH + 10;
   localparam logic [AW-1:0] CYCLES_PER_US = AW'(1000 / CLK_PERIOD);

   logic [AW-1:0] c;          // phase counter, 0..TOTAL-1
   logic [AW-1:0] total_q;    // latched TOTAL
   logic [AW-1:0] high_q;     // latched HIGH

   logic [AW-1:0] new_total;
   logic [AW-1:0] new_high;
   logic [AW-1:0] cur_total;
   logic [AW-1:0] cur_high;
   logic          last;

   function automatic logic [AW-1:0] to_cycles(input logic [PERIOD_WIDTH-1:0] p);
      logic [AW-1:0] pw;
      pw = {10'b0, p};
      return pw * CYCLES_PER_US;
   endfunction

   // At phase 0 the freshly computed values drive this edge's decision, so a
   // new period takes effect immediately and never mid-period.
   always_comb begin
      new_total = to_cycles(pwm_period);
      new_high  = new_total >> 1;
      cur_total = total_q;
      cur_high  = high_q;
      if (c == '0) begin
         cur_total = new_total;
         cur_high  = new_high;
      end
      // TOTAL=0 keeps the counter parked at 0 so the period is re-sampled
      // on every edge.
      last = (cur_total == '0) || (c == cur_total - AW'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out     <= 1'b0;
         c       <= '0;
         total_q <= '0;
         high_q  <= '0;
      end else if (!enable) begin
         out <= 1'b0;
         c   <= '0;
      end else begin
         if (c == '0) begin
            total_q <= new_total;
            high_q  <= new_high;
         end
         out <= (c < cur_high);
         c   <= last ? '0 : c + AW'(1);
      end
   end

endmodule

// File: tb/tb_pwm.sv
// ----------------------------------------------------------------------------
// tb_pwm -- directed bench for pwm. Three instances with different CLK_PERIOD
// values share one clock and reset; each section drives one of them.
// ----------------------------------------------------------------------------
module tb_pwm;

   logic        clk = 1'b0;
   logic        rst;
   logic        en20, en10, en1k;
   logic [15:0] per20, per10, per1k;
   logic        out20, out10, out1k;

   int n_asrt = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pwm #(.CLK_PERIOD(20),   .PERIOD_WIDTH(16)) u20 (
      .clk(clk), .rst(rst), .enable(en20), .pwm_period(per20), .out(out20));
   pwm #(.CLK_PERIOD(10),   .PERIOD_WIDTH(16)) u10 (
      .clk(clk), .rst(rst), .enable(en10), .pwm_period(per10), .out(out10));
   pwm #(.CLK_PERIOD(1000), .PERIOD_WIDTH(16)) u1k (
      .clk(clk), .rst(rst), .enable(en1k), .pwm_period(per1k), .out(out1k));

   // Advance one rising edge and settle before sampling / driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset with every instance enabled: reset must win.
      rst   = 1'b1;
      en20  = 1'b1; en10 = 1'b1; en1k = 1'b1;
      per20 = 16'd13; per10 = 16'd3; per1k = 16'd3;
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("rst20_%0d", i), out20, 1'b0);
         chk($sformatf("rst10_%0d", i), out10, 1'b0);
         chk($sformatf("rst1k_%0d", i), out1k, 1'b0);
      end
      rst  = 1'b0;
      en10 = 1'b0;
      en1k = 1'b0;

      // CLK_PERIOD=20, 13 us -> 650 cycles: 325 high, 325 low, 3 periods.
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 650; i++) begin
            step();
            chk($sformatf("p13_k%0d_i%0d", k, i), out20, (i < 325) ? 1'b1 : 1'b0);
         end
      end
      en20 = 1'b0;
      step();
      chk("p13_disable", out20, 1'b0);

      // CLK_PERIOD=10, 3 us -> 300 cycles; switch to 5 us at cycle 100.
      en10 = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
         chk($sformatf("p3_i%0d", i), out10, (i < 150) ? 1'b1 : 1'b0);
         if (i == 100) per10 = 16'd5;
      end
      for (int i = 0; i < 500; i++) begin
         step();
         chk($sformatf("p5_i%0d", i), out10, (i < 250) ? 1'b1 : 1'b0);
      end
      en10 = 1'b0;
      step();
      chk("p5_disable", out10, 1'b0);

      // CLK_PERIOD=1000, 3 us -> 1 high, 2 low.
      en1k = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         chk($sformatf("p3us_i%0d", i), out1k, (i % 3 == 0) ? 1'b1 : 1'b0);
      end
      // TOTAL=1 -> never high.
      per1k = 16'd1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("p1_i%0d", i), out1k, 1'b0);
      end
      // TOTAL=0 -> never high.
      per1k = 16'd0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("p0_i%0d", i), out1k, 1'b0);
      end
      // 2 us picked up on the very next edge: 1,0,1,0,...
      per1k = 16'd2;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("p2_i%0d", i), out1k, (i % 2 == 0) ? 1'b1 : 1'b0);
      end

      // Enable drop mid high-phase, then restart with a full pulse.
      en1k = 1'b0;
      step();
      chk("en_idle", out1k, 1'b0);
      per1k = 16'd6;
      en1k  = 1'b1;
      step(); chk("en_hi0", out1k, 1'b1);
      step(); chk("en_hi1", out1k, 1'b1);
      en1k = 1'b0;
      step(); chk("en_drop0", out1k, 1'b0);
      step(); chk("en_drop1", out1k, 1'b0);
      en1k = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("en_re_i%0d", i), out1k, (i < 3) ? 1'b1 : 1'b0);
      end

      // Reset while running, then restart from phase 0.
      step(); chk("rr_hi0", out1k, 1'b1);
      step(); chk("rr_hi1", out1k, 1'b1);
      rst = 1'b1;
      step(); chk("rr_rst", out1k, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("rr_re_i%0d", i), out1k, (i < 3) ? 1'b1 : 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
